multi_digit_comparator_display: RTL and testbench

MULTI_DIGIT_COMPARATOR_DISPLAY -- requirements
Module: multi_digit_comparator_display

---
 rtl/multi_digit_comparator_display.sv | 129 ++++++++++++
 tb/tb_multi_digit_comparator_display.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/multi_digit_comparator_display.sv
// Registered two-operand unsigned comparator with a multiplexed hex seven-segment display.
// Define LEADING_ZERO_BLANK_EN at compile time to blank leading zero digits.
module multi_digit_comparator_display #(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             x,
  output logic             eq,
  output logic [WIDTH-1:0] bigger,
  output logic [7:0]       D,
  output logic [3:0]       ssd_active
);

  localparam int NDIG = WIDTH / 4;
  localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(NDIG - 1);

  logic [WIDTH-1:0] cap_a_q, cap_a_d;
  logic [WIDTH-1:0] cap_b_q, cap_b_d;
  logic             x_q, x_d;
  logic             eq_q, eq_d;
  logic [WIDTH-1:0] bigger_q, bigger_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       ssd_q, ssd_d;

  logic             tick;
  logic [15:0]      big16;
  logic [3:0]       nibble;
  logic [7:0]       glyph;
  logic             blank;

  always_comb begin
    cap_a_d  = hold ? cap_a_q : a;
    cap_b_d  = hold ? cap_b_q : b;
    x_d      = cap_a_q > cap_b_q;
    eq_d     = cap_a_q == cap_b_q;
    bigger_d = x_d ? cap_a_q : cap_b_q;
  end

  // Free-running refresh scan, independent of hold and the operand pipeline.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? 2'd0 : idx_q + 2'd1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] upper;
  always_comb begin
    upper = big16 >> {idx_q, 2'b00};
    blank = (idx_q != 2'd0) && (upper == 16'h0000);
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_comb begin
    big16  = 16'(bigger_q);
    nibble = big16[{idx_q, 2'b00} +: 4];
    case (nibble)
      4'h0: glyph = 8'h03;
      4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;
      4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;
      4'h7: glyph = 8'h1B;
      4'h8: glyph = 8'h01;
      4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;
      4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;
      4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;
      default: glyph = 8'h71;
    endcase
    seg_d = glyph;
    ssd_d = 4'hF & ~(4'b0001 << idx_q);
    if (blank) begin
      seg_d = 8'hFF;
      ssd_d = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_a_q  <= '0;
      cap_b_q  <= '0;
      x_q      <= 1'b0;
      eq_q     <= 1'b0;
      bigger_q <= '0;
      presc_q  <= '0;
      idx_q    <= 2'd0;
      seg_q    <= 8'hFF;
      ssd_q    <= 4'hF;
    end else begin
      cap_a_q  <= cap_a_d;
      cap_b_q  <= cap_b_d;
      x_q      <= x_d;
      eq_q     <= eq_d;
      bigger_q <= bigger_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      ssd_q    <= ssd_d;
    end
  end

  assign x          = x_q;
  assign eq         = eq_q;
  assign bigger     = bigger_q;
  assign D          = seg_q;
  assign ssd_active = ssd_q;

endmodule

// File: tb/tb_multi_digit_comparator_display.sv
// Directed self-checking bench: an 8-bit and a 16-bit instance share clock and reset.
module tb_multi_digit_comparator_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold8, hold16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        x8, eq8, x16, eq16;
  logic [7:0]  big8, d8, d16;
  logic [15:0] big16;
  logic [3:0]  ssd8, ssd16;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] seqSsd [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] seqSeg [4] = '{8'h9F, 8'h25, 8'h99, 8'h01};

  always #5 clk = ~clk;

  multi_digit_comparator_display #(.WIDTH(8), .REFRESH_DIV(4)) u8 (
    .clk(clk), .rst_n(rst_n), .hold(hold8), .a(a8), .b(b8),
    .x(x8), .eq(eq8), .bigger(big8), .D(d8), .ssd_active(ssd8)
  );

  multi_digit_comparator_display #(.WIDTH(16), .REFRESH_DIV(4)) u16 (
    .clk(clk), .rst_n(rst_n), .hold(hold16), .a(a16), .b(b16),
    .x(x16), .eq(eq16), .bigger(big16), .D(d16), .ssd_active(ssd16)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the 8-bit instance's operands and hold.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic h);
    a8    = av;
    b8    = bv;
    hold8 = h;
  endtask

  // Step at least once, then until the chosen instance shows the wanted enable pattern.
  task automatic waitSsd(input bit wide, input logic [3:0] exp, input string tag);
    stepCycles(1);
    for (int i = 0; i < 24; i++) begin
      if ((wide ? ssd16 : ssd8) == exp) break;
      stepCycles(1);
    end
    checkOutput(tag, 16'(wide ? ssd16 : ssd8), 16'(exp));
  endtask

  initial begin
    rst_n  = 1'b0;
    hold16 = 1'b0;
    a16    = 16'h8421;
    b16    = 16'h0000;
    applyStimulus(8'h00, 8'h00, 1'b0);
    stepCycles(2);
    checkOutput("rst_D", 16'(d8), 16'h00FF);
    checkOutput("rst_ssd", 16'(ssd8), 16'h000F);
    checkOutput("rst_x", 16'(x8), 16'h0);
    checkOutput("rst_eq", 16'(eq8), 16'h0);
    checkOutput("rst_bigger", 16'(big8), 16'h0);
    rst_n = 1'b1;
    checkOutput("post_rst_D", 16'(d8), 16'h00FF);
    checkOutput("post_rst_ssd", 16'(ssd8), 16'h000F);

    applyStimulus(8'h5A, 8'h3C, 1'b0);
    stepCycles(1);
    checkOutput("lat1_x", 16'(x8), 16'h0);
    checkOutput("lat1_bigger", 16'(big8), 16'h0);
    stepCycles(1);
    checkOutput("5A3C_x", 16'(x8), 16'h1);
    checkOutput("5A3C_eq", 16'(eq8), 16'h0);
    checkOutput("5A3C_bigger", 16'(big8), 16'h5A);
    waitSsd(1'b0, 4'hE, "5A3C_dig0_ssd");
    checkOutput("5A3C_dig0_D", 16'(d8), 16'h11);
    waitSsd(1'b0, 4'hD, "5A3C_dig1_ssd");
    checkOutput("5A3C_dig1_D", 16'(d8), 16'h49);

    applyStimulus(8'h77, 8'h77, 1'b0);
    stepCycles(2);
    checkOutput("77_x", 16'(x8), 16'h0);
    checkOutput("77_eq", 16'(eq8), 16'h1);
    checkOutput("77_bigger", 16'(big8), 16'h77);

    applyStimulus(8'h00, 8'hFF, 1'b0);
    stepCycles(2);
    checkOutput("00FF_x", 16'(x8), 16'h0);
    checkOutput("00FF_eq", 16'(eq8), 16'h0);
    checkOutput("00FF_bigger", 16'(big8), 16'hFF);
    waitSsd(1'b0, 4'hE, "00FF_dig0_ssd");
    checkOutput("00FF_dig0_D", 16'(d8), 16'h71);
    waitSsd(1'b0, 4'hD, "00FF_dig1_ssd");
    checkOutput("00FF_dig1_D", 16'(d8), 16'h71);

    applyStimulus(8'h12, 8'h34, 1'b0);
    stepCycles(2);
    checkOutput("1234_bigger", 16'(big8), 16'h34);
    applyStimulus(8'hF0, 8'h34, 1'b1);
    stepCycles(3);
    checkOutput("hold_x", 16'(x8), 16'h0);
    checkOutput("hold_bigger", 16'(big8), 16'h34);
    applyStimulus(8'hF0, 8'h34, 1'b0);
    stepCycles(1);
    checkOutput("rel1_bigger", 16'(big8), 16'h34);
    stepCycles(1);
    checkOutput("rel2_x", 16'(x8), 16'h1);
    checkOutput("rel2_bigger", 16'(big8), 16'hF0);

    checkOutput("w16_bigger", big16, 16'h8421);
    checkOutput("w16_x", 16'(x16), 16'h1);
    waitSsd(1'b1, 4'h7, "scan_sync7");
    waitSsd(1'b1, 4'hE, "scan_syncE");
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("scan_ssd%0d", k), 16'(ssd16), 16'(seqSsd[k/4]));
      checkOutput($sformatf("scan_D%0d", k), 16'(d16), 16'(seqSeg[k/4]));
      stepCycles(1);
    end

    a16 = 16'h0003;
    stepCycles(3);
    waitSsd(1'b1, 4'hE, "blank_syncE");
    checkOutput("blank_dig0_D", 16'(d16), 16'h0D);
    for (int i = 1; i < 4; i++) begin
      stepCycles(4);
`ifdef LEADING_ZERO_BLANK_EN
      checkOutput($sformatf("blank_dig%0d_D", i), 16'(d16), 16'h00FF);
      checkOutput($sformatf("blank_dig%0d_ssd", i), 16'(ssd16), 16'h000F);
`else
      checkOutput($sformatf("blank_dig%0d_D", i), 16'(d16), 16'h0003);
      checkOutput($sformatf("blank_dig%0d_ssd", i), 16'(ssd16), 16'(seqSsd[i]));
`endif
    end

    a16 = 16'h8421;
    stepCycles(3);
    waitSsd(1'b1, 4'hB, "mid_syncB");
    rst_n = 1'b0;
    stepCycles(1);
    checkOutput("mid_rst_ssd", 16'(ssd16), 16'h000F);
    checkOutput("mid_rst_D", 16'(d16), 16'h00FF);
    checkOutput("mid_rst_bigger8", 16'(big8), 16'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stepCycles(1);
      checkOutput($sformatf("mid_restart%0d", k), 16'(ssd16), 16'h000E);
    end
    stepCycles(1);
    checkOutput("mid_advance", 16'(ssd16), 16'h000D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
